// File: rtl/rnn_pkg.sv
// Shared widths, saturation limits and FSM state encoding for the
// fixed-point matrix-vector datapath.
package rnn_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ACC_W  = 40;

    localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StWrite,
        StDone
    } state_e;

endpackage

// File: rtl/fxp_sat.sv
// Rescales a wide signed accumulator by FRAC_BITS (floor) and clamps it
// to the signed DATA_W range.
module fxp_sat
    import rnn_pkg::*;
#(
    parameter int unsigned FRAC_BITS = 8
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    output logic        [DATA_W-1:0] o_data
);

    logic signed [ACC_W-1:0] w_shift;
    logic signed [ACC_W-1:0] w_max;
    logic signed [ACC_W-1:0] w_min;

    // Arithmetic shift rounds toward minus infinity.
    assign w_shift = i_acc >>> FRAC_BITS;
    assign w_max   = $signed({{(ACC_W-DATA_W){1'b0}}, SAT_MAX});
    assign w_min   = $signed({{(ACC_W-DATA_W){1'b1}}, SAT_MIN});

    always_comb begin
        o_data = w_shift[DATA_W-1:0];
        if (w_shift > w_max) begin
            o_data = SAT_MAX;
        end else if (w_shift < w_min) begin
            o_data = SAT_MIN;
        end
    end

endmodule

// File: rtl/matvec_mac.sv
// Sequential matrix-vector multiplier: one MAC per cycle per column, then a
// saturated write per row, then a one-cycle done pulse.
module matvec_mac
    import rnn_pkg::*;
#(
    parameter int unsigned ROWS      = 2,
    parameter int unsigned COLS      = 4,
    parameter int unsigned FRAC_BITS = 8,
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [RW-1:0]            w_seli,
    output logic [CW-1:0]            w_selj,
    input  logic signed [DATA_W-1:0] w_data,
    output logic [3:0]               x_sel,
    input  logic signed [DATA_W-1:0] x_data,
    output logic                     y_write,
    output logic [3:0]               y_sel,
    output logic [DATA_W-1:0]        y_data
);

    localparam logic [RW-1:0] LAST_I = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_J = CW'(COLS - 1);

    state_e                    r_state, w_state_d;
    logic [RW-1:0]             r_i, w_i_d;
    logic [CW-1:0]             r_j, w_j_d;
    logic signed [ACC_W-1:0]   r_acc, w_acc_d;
    logic [DATA_W-1:0]         r_y, w_y_d;
    logic [DATA_W-1:0]         w_sat;
    logic signed [2*DATA_W-1:0] w_prod;

    assign w_prod = w_data * x_data;

    fxp_sat #(
        .FRAC_BITS(FRAC_BITS)
    ) u_sat (
        .i_acc (r_acc),
        .o_data(w_sat)
    );

    always_comb begin
        w_state_d = r_state;
        w_i_d     = r_i;
        w_j_d     = r_j;
        w_acc_d   = r_acc;
        w_y_d     = r_y;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d = StMac;
                    w_i_d     = '0;
                    w_j_d     = '0;
                    w_acc_d   = '0;
                end
            end
            StMac: begin
                w_acc_d = r_acc + $signed({{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod});
                if (r_j == LAST_J) begin
                    w_state_d = StWrite;
                end else begin
                    w_j_d = r_j + CW'(1);
                end
            end
            StWrite: begin
                w_y_d = w_sat;
                if (r_i == LAST_I) begin
                    w_state_d = StDone;
                end else begin
                    w_state_d = StMac;
                    w_i_d     = r_i + RW'(1);
                    w_j_d     = '0;
                    w_acc_d   = '0;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_i     <= '0;
            r_j     <= '0;
            r_acc   <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_d;
            r_i     <= w_i_d;
            r_j     <= w_j_d;
            r_acc   <= w_acc_d;
            r_y     <= w_y_d;
        end
    end

    assign busy    = (r_state == StMac) || (r_state == StWrite);
    assign done    = (r_state == StDone);
    assign y_write = (r_state == StWrite);
    assign w_seli  = r_i;
    assign w_selj  = r_j;
    assign x_sel   = 4'(r_j);
    assign y_sel   = 4'(r_i);
    // Result is visible during the write cycle and held in r_y afterwards.
    assign y_data  = y_write ? w_sat : r_y;

endmodule

// File: tb/tb_matvec_mac.sv
// Directed bench for matvec_mac at default parameters (2x4, Q8).
module tb_matvec_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [0:0]  w_seli;
    logic [1:0]  w_selj;
    logic [15:0] w_data;
    logic [3:0]  x_sel;
    logic [15:0] x_data;
    logic        y_write;
    logic [3:0]  y_sel;
    logic [15:0] y_data;

    logic [15:0] w_mem [2][4];
    logic [15:0] x_mem [16];

    int n_cmp = 0;
    int n_err = 0;

    int          wr_cnt;
    int          dn_cnt;
    int          dn_cyc;
    int          busy_late;
    logic [15:0] y_obs [2];
    logic [3:0]  sel_obs [2];

    always #5 clk = ~clk;

    assign w_data = w_mem[w_seli][w_selj];
    assign x_data = x_mem[x_sel];

    matvec_mac dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .w_seli (w_seli),
        .w_selj (w_selj),
        .w_data (w_data),
        .x_sel  (x_sel),
        .x_data (x_data),
        .y_write(y_write),
        .y_sel  (y_sel),
        .y_data (y_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [15:0] wr0, input logic [15:0] wr1, input logic [15:0] xv);
        for (int j = 0; j < 4; j++) begin
            w_mem[0][j] = wr0;
            w_mem[1][j] = wr1;
        end
        for (int k = 0; k < 16; k++) x_mem[k] = (k < 4) ? xv : 16'h0000;
    endtask

    // Starts one product; cycle 1 is the first cycle after the sampling edge.
    // start is re-raised in cycles p1/p2 and rst in cycle rst_at (0 = never).
    task automatic run(input int p1, input int p2, input int rst_at);
        wr_cnt    = 0;
        dn_cnt    = 0;
        dn_cyc    = 0;
        busy_late = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 1; n <= 14; n++) begin
            start = (n == p1) || (n == p2);
            rst   = (n == rst_at);
            if (y_write) begin
                if (wr_cnt < 2) begin
                    y_obs[wr_cnt]   = y_data;
                    sel_obs[wr_cnt] = y_sel;
                end
                wr_cnt++;
            end
            if (done) begin
                dn_cnt++;
                dn_cyc = n;
            end
            if (rst_at > 0 && n > rst_at && busy) busy_late++;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic check_product(input string tag, input logic [15:0] y0, input logic [15:0] y1);
        check({tag, ".writes"}, wr_cnt, 2);
        check({tag, ".sel0"}, sel_obs[0], 0);
        check({tag, ".y0"}, y_obs[0], y0);
        check({tag, ".sel1"}, sel_obs[1], 1);
        check({tag, ".y1"}, y_obs[1], y1);
        check({tag, ".done_cnt"}, dn_cnt, 1);
        check({tag, ".done_cyc"}, dn_cyc, 11);
        check({tag, ".idle_busy"}, busy, 0);
        check({tag, ".hold"}, y_data, y1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        load(16'h0000, 16'h0000, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.y_write", y_write, 0);
        check("rst.w_seli", w_seli, 0);
        check("rst.w_selj", w_selj, 0);
        check("rst.x_sel", x_sel, 0);
        check("rst.y_sel", y_sel, 0);
        check("rst.y_data", y_data, 0);
        rst = 1'b0;

        // Row 0 scaled by 1.0 against 1,2,3,4 -> 10.0; row 1 zero.
        load(16'h0100, 16'h0000, 16'h0000);
        x_mem[0] = 16'h0100;
        x_mem[1] = 16'h0200;
        x_mem[2] = 16'h0300;
        x_mem[3] = 16'h0400;
        run(0, 0, 0);
        check_product("basic", 16'h0A00, 16'h0000);

        load(16'h7FFF, 16'h7FFF, 16'h7FFF);
        run(0, 0, 0);
        check_product("sat_pos", 16'h7FFF, 16'h7FFF);

        load(16'h8000, 16'h8000, 16'h7FFF);
        run(0, 0, 0);
        check_product("sat_neg", 16'h8000, 16'h8000);

        // -1.0 * 0.5 = -0.5
        load(16'h0000, 16'h0000, 16'h0000);
        w_mem[0][0] = 16'hFF00;
        x_mem[0]    = 16'h0080;
        run(0, 0, 0);
        check_product("neg_half", 16'hFF80, 16'h0000);

        // -1 LSB^2 floors to -1 LSB rather than 0.
        w_mem[0][0] = 16'hFFFF;
        x_mem[0]    = 16'h0001;
        run(0, 0, 0);
        check_product("floor", 16'hFFFF, 16'h0000);

        load(16'h0100, 16'h0000, 16'h0000);
        x_mem[0] = 16'h0100;
        x_mem[1] = 16'h0200;
        x_mem[2] = 16'h0300;
        x_mem[3] = 16'h0400;
        run(3, 11, 0);
        check_product("start_ignored", 16'h0A00, 16'h0000);

        run(0, 0, 3);
        check("abort.writes", wr_cnt, 0);
        check("abort.done", dn_cnt, 0);
        check("abort.busy", busy_late, 0);
        check("abort.y_data", y_data, 0);
        check("abort.w_selj", w_selj, 0);
        check("abort.y_sel", y_sel, 0);

        run(0, 0, 0);
        check_product("after_abort", 16'h0A00, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
